// File: rtl/branch_resolve_pkg.sv
// Shared decode constants and FSM state type for the execute-stage branch resolver.
package branch_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } br_state_e;

  // Unsigned rs1<rs2 from the signed compare: differing MSBs invert the result.
  function automatic logic unsigned_lt(input logic brlt, input logic rs1_msb, input logic rs2_msb);
    return brlt ^ (rs1_msb ^ rs2_msb);
  endfunction

endpackage

// File: rtl/branch_resolve_if.sv
// Execute-stage/fetch signal bundle for branch_resolve; slave is the resolver side.
interface branch_resolve_if #(
  parameter int AWIDTH    = 32,
  parameter int CNT_WIDTH = 32
);
  logic                 valid_i;
  logic [6:0]           opcode_i;
  logic [2:0]           funct3_i;
  logic [AWIDTH-1:0]    pc_i;
  logic [AWIDTH-1:0]    imm_i;
  logic [AWIDTH-1:0]    jalr_base_i;
  logic                 rs1_msb_i;
  logic                 rs2_msb_i;
  logic                 breq_i;
  logic                 brlt_i;
  logic                 redirect_ready_i;
  logic                 redirect_valid_o;
  logic [AWIDTH-1:0]    redirect_pc_o;
  logic                 flush_o;
  logic                 stall_o;
  logic                 illegal_o;
  logic [CNT_WIDTH-1:0] branch_cnt_o;
  logic [CNT_WIDTH-1:0] taken_cnt_o;

  modport master (
    output valid_i, opcode_i, funct3_i, pc_i, imm_i, jalr_base_i,
           rs1_msb_i, rs2_msb_i, breq_i, brlt_i, redirect_ready_i,
    input  redirect_valid_o, redirect_pc_o, flush_o, stall_o, illegal_o,
           branch_cnt_o, taken_cnt_o
  );

  modport slave (
    input  valid_i, opcode_i, funct3_i, pc_i, imm_i, jalr_base_i,
           rs1_msb_i, rs2_msb_i, breq_i, brlt_i, redirect_ready_i,
    output redirect_valid_o, redirect_pc_o, flush_o, stall_o, illegal_o,
           branch_cnt_o, taken_cnt_o
  );
endinterface

// File: rtl/branch_resolve_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] value
);
  logic [WIDTH-1:0] r_value;

  always_ff @(posedge clk) begin
    if (clear)
      r_value <= '0;
    else if (inc && (r_value != '1))
      r_value <= r_value + 1'b1;
  end

  assign value = r_value;
endmodule

// File: rtl/branch_resolve.sv
// Resolves branch/JAL/JALR in execute, hands the redirect to fetch, then flushes
// younger stages for FLUSH_CYCLES cycles while stalling upstream.
module branch_resolve
  import branch_pkg::*;
#(
  parameter int AWIDTH       = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 32
) (
  input logic           clk,
  input logic           reset,
  branch_resolve_if.slave bus
);
  localparam int FCW = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);

  br_state_e         r_state;
  br_state_e         w_state_nxt;
  logic [AWIDTH-1:0] r_redirect_pc;
  logic              r_illegal;
  logic [FCW-1:0]    r_flush_cnt;

  logic              w_sample;
  logic              w_is_br;
  logic              w_is_jal;
  logic              w_is_jalr;
  logic              w_ltu;
  logic              w_taken;
  logic              w_illegal;
  logic              w_accept;
  logic [AWIDTH-1:0] w_target;
  logic [CNT_WIDTH-1:0] w_branch_cnt;
  logic [CNT_WIDTH-1:0] w_taken_cnt;

  assign w_sample = bus.valid_i && (r_state == IDLE);
  assign w_accept = (r_state == REDIRECT) && bus.redirect_ready_i;

  always_comb begin
    w_is_br   = (bus.opcode_i == OP_BRANCH);
    w_is_jal  = (bus.opcode_i == OP_JAL);
    w_is_jalr = (bus.opcode_i == OP_JALR);
    w_ltu     = unsigned_lt(bus.brlt_i, bus.rs1_msb_i, bus.rs2_msb_i);
    w_taken   = 1'b0;
    w_illegal = 1'b0;
    if (w_is_br) begin
      case (bus.funct3_i)
        F3_BEQ:  w_taken = bus.breq_i;
        F3_BNE:  w_taken = !bus.breq_i;
        F3_BLT:  w_taken = bus.brlt_i;
        F3_BGE:  w_taken = !bus.brlt_i;
        F3_BLTU: w_taken = w_ltu;
        F3_BGEU: w_taken = !w_ltu;
        default: w_illegal = 1'b1;
      endcase
    end else if (w_is_jal || w_is_jalr) begin
      w_taken = 1'b1;
    end
    w_target = w_is_jalr ? {bus.jalr_base_i[AWIDTH-1:1], 1'b0}
                         : bus.pc_i + bus.imm_i;
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (w_sample && w_taken) w_state_nxt = REDIRECT;
      REDIRECT: if (bus.redirect_ready_i) w_state_nxt = (FLUSH_CYCLES == 0) ? IDLE : FLUSH;
      FLUSH:    if (r_flush_cnt <= FCW'(1)) w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_redirect_pc <= '0;
      r_illegal     <= 1'b0;
      r_flush_cnt   <= '0;
    end else begin
      r_illegal <= w_sample && w_illegal;
      if (w_sample && w_taken)
        r_redirect_pc <= w_target;
      // Counter is loaded on accept so flush_o spans exactly FLUSH_CYCLES cycles.
      if (w_accept)
        r_flush_cnt <= FCW'(FLUSH_CYCLES);
      else if ((r_state == FLUSH) && (r_flush_cnt != '0))
        r_flush_cnt <= r_flush_cnt - 1'b1;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_branch_cnt (
    .clk   (clk),
    .inc   (w_sample && (w_is_br || w_is_jal || w_is_jalr)),
    .clear (reset),
    .value (w_branch_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_taken_cnt (
    .clk   (clk),
    .inc   (w_sample && w_taken),
    .clear (reset),
    .value (w_taken_cnt)
  );

  assign bus.redirect_valid_o = (r_state == REDIRECT);
  assign bus.redirect_pc_o    = r_redirect_pc;
  assign bus.flush_o          = (r_state == FLUSH);
  assign bus.stall_o          = (r_state != IDLE);
  assign bus.illegal_o        = r_illegal;
  assign bus.branch_cnt_o     = w_branch_cnt;
  assign bus.taken_cnt_o      = w_taken_cnt;
endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed table, corner sequences, random vs. model.
module tb_branch_resolve;
  localparam int AW   = 32;
  localparam int FC   = 2;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  localparam logic [6:0] T_BR   = 7'b1100011;
  localparam logic [6:0] T_JAL  = 7'b1101111;
  localparam logic [6:0] T_JALR = 7'b1100111;
  localparam logic [6:0] T_ALU  = 7'b0110011;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_resolve_if #(.AWIDTH(AW), .CNT_WIDTH(CW)) bus ();

  branch_resolve #(.AWIDTH(AW), .FLUSH_CYCLES(FC), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] rs1_v, rs2_v;

  // Reference model: pending redirect, flush cycles left, counters as plain ints.
  bit          m_pend;
  logic [31:0] m_pc;
  int          m_flush;
  bit          m_ill;
  int          m_bc, m_tc;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] pc, imm, r1, r2;
    bit          exp_taken;
    logic [31:0] exp_pc;
    bit          exp_ill;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] pc, input logic [31:0] imm,
                       input logic [31:0] r1, input logic [31:0] r2);
    rs1_v           = r1;
    rs2_v           = r2;
    bus.valid_i     = v;
    bus.opcode_i    = op;
    bus.funct3_i    = f3;
    bus.pc_i        = pc;
    bus.imm_i       = imm;
    bus.jalr_base_i = r1 + imm;
    bus.rs1_msb_i   = r1[31];
    bus.rs2_msb_i   = r2[31];
    bus.breq_i      = (r1 == r2);
    bus.brlt_i      = ($signed(r1) < $signed(r2));
  endtask

  function automatic int sat(input int x);
    return (x > CMAX) ? CMAX : x;
  endfunction

  task automatic model_step();
    bit          taken;
    logic [31:0] tgt;
    if (reset) begin
      m_pend = 0; m_pc = '0; m_flush = 0; m_ill = 0; m_bc = 0; m_tc = 0;
      return;
    end
    m_ill = 0;
    taken = 0;
    tgt   = '0;
    if (m_pend) begin
      if (bus.redirect_ready_i) begin
        m_pend  = 0;
        m_flush = FC;
      end
    end else if (m_flush > 0) begin
      m_flush--;
    end else if (bus.valid_i) begin
      if (bus.opcode_i == T_BR) begin
        m_bc = sat(m_bc + 1);
        tgt  = bus.pc_i + bus.imm_i;
        case (bus.funct3_i)
          3'd0: taken = (rs1_v == rs2_v);
          3'd1: taken = (rs1_v != rs2_v);
          3'd4: taken = ($signed(rs1_v) <  $signed(rs2_v));
          3'd5: taken = ($signed(rs1_v) >= $signed(rs2_v));
          3'd6: taken = (rs1_v <  rs2_v);
          3'd7: taken = (rs1_v >= rs2_v);
          default: m_ill = 1;
        endcase
      end else if (bus.opcode_i == T_JAL) begin
        m_bc = sat(m_bc + 1);
        taken = 1;
        tgt  = bus.pc_i + bus.imm_i;
      end else if (bus.opcode_i == T_JALR) begin
        m_bc = sat(m_bc + 1);
        taken = 1;
        tgt  = (rs1_v + bus.imm_i) & 32'hFFFF_FFFE;
      end
      if (taken) begin
        m_tc   = sat(m_tc + 1);
        m_pend = 1;
        m_pc   = tgt;
      end
    end
  endtask

  task automatic check_all();
    chk("m_redirect_valid", bus.redirect_valid_o, m_pend);
    if (m_pend) chk("m_redirect_pc", bus.redirect_pc_o, m_pc);
    chk("m_flush", bus.flush_o, m_flush > 0);
    chk("m_stall", bus.stall_o, m_pend || (m_flush > 0));
    chk("m_illegal", bus.illegal_o, m_ill);
    chk("m_branch_cnt", bus.branch_cnt_o, m_bc);
    chk("m_taken_cnt", bus.taken_cnt_o, m_tc);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 20 && bus.stall_o; i++) tick();
    chk(name, bus.stall_o, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{T_BR,   3'd0, 32'h100,       32'h20,        32'd5,         32'd5, 1, 32'h120,  0};
    tbl[1]  = '{T_BR,   3'd0, 32'h100,       32'h20,        32'd5,         32'd6, 0, 32'h0,    0};
    tbl[2]  = '{T_BR,   3'd1, 32'h200,       32'hFFFF_FFF0, 32'd5,         32'd6, 1, 32'h1F0,  0};
    tbl[3]  = '{T_BR,   3'd4, 32'h300,       32'h8,         32'hFFFF_FFFF, 32'd1, 1, 32'h308,  0};
    tbl[4]  = '{T_BR,   3'd5, 32'h300,       32'h8,         32'hFFFF_FFFF, 32'd1, 0, 32'h0,    0};
    tbl[5]  = '{T_BR,   3'd6, 32'h400,       32'h40,        32'hFFFF_FFFF, 32'd1, 0, 32'h0,    0};
    tbl[6]  = '{T_BR,   3'd7, 32'h400,       32'h40,        32'hFFFF_FFFF, 32'd1, 1, 32'h440,  0};
    tbl[7]  = '{T_BR,   3'd2, 32'h500,       32'h40,        32'd3,         32'd3, 0, 32'h0,    1};
    tbl[8]  = '{T_JAL,  3'd0, 32'hFFFF_FFF0, 32'h20,        32'd0,         32'd0, 1, 32'h10,   0};
    tbl[9]  = '{T_JALR, 3'd0, 32'h600,       32'h3,         32'h2000,      32'd0, 1, 32'h2002, 0};
    tbl[10] = '{T_ALU,  3'd0, 32'h700,       32'h4,         32'd1,         32'd2, 0, 32'h0,    0};

    reset = 1'b1;
    bus.redirect_ready_i = 1'b0;
    drive(0, T_ALU, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    tick();
    chk("reset_redirect_valid", bus.redirect_valid_o, 0);
    chk("reset_redirect_pc", bus.redirect_pc_o, 0);
    chk("reset_stall", bus.stall_o, 0);
    chk("reset_flush", bus.flush_o, 0);
    chk("reset_branch_cnt", bus.branch_cnt_o, 0);
    chk("reset_taken_cnt", bus.taken_cnt_o, 0);
    reset = 1'b0;

    // Directed table, one instruction at a time from IDLE.
    bus.redirect_ready_i = 1'b1;
    for (int i = 0; i < 11; i++) begin
      drive(1, tbl[i].op, tbl[i].f3, tbl[i].pc, tbl[i].imm, tbl[i].r1, tbl[i].r2);
      tick();
      chk("tbl_redirect_valid", bus.redirect_valid_o, tbl[i].exp_taken);
      if (tbl[i].exp_taken) chk("tbl_redirect_pc", bus.redirect_pc_o, tbl[i].exp_pc);
      chk("tbl_illegal", bus.illegal_o, tbl[i].exp_ill);
      drive(0, T_ALU, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
      wait_idle("tbl_idle_timeout");
    end

    // BEQ taken: one redirect cycle, then exactly two flush cycles.
    do_reset();
    bus.redirect_ready_i = 1'b1;
    drive(1, T_BR, 3'd0, 32'h100, 32'h20, 32'd9, 32'd9);
    tick();
    chk("beq_rv", bus.redirect_valid_o, 1);
    chk("beq_pc", bus.redirect_pc_o, 32'h120);
    chk("beq_stall", bus.stall_o, 1);
    drive(0, T_ALU, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    chk("beq_rv_drop", bus.redirect_valid_o, 0);
    chk("beq_flush1", bus.flush_o, 1);
    tick();
    chk("beq_flush2", bus.flush_o, 1);
    tick();
    chk("beq_flush_end", bus.flush_o, 0);
    chk("beq_stall_end", bus.stall_o, 0);

    // BLTU with rs1=0xFFFFFFFF, rs2=1: signed lt but unsigned not lt.
    do_reset();
    drive(1, T_BR, 3'd6, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'd1);
    tick();
    drive(0, T_ALU, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("bltu_rv", bus.redirect_valid_o, 0);
    chk("bltu_branch_cnt", bus.branch_cnt_o, 1);
    chk("bltu_taken_cnt", bus.taken_cnt_o, 0);

    // JALR with fetch not ready: target held, stall high, new valid ignored.
    bus.redirect_ready_i = 1'b0;
    drive(1, T_JALR, 3'd0, 32'h0, 32'h3, 32'h2000, 32'd0);
    tick();
    drive(1, T_JAL, 3'd0, 32'h800, 32'h40, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("jalr_rv_hold", bus.redirect_valid_o, 1);
      chk("jalr_pc_hold", bus.redirect_pc_o, 32'h2002);
      chk("jalr_stall", bus.stall_o, 1);
      tick();
    end
    drive(0, T_ALU, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    bus.redirect_ready_i = 1'b1;
    tick();
    chk("jalr_flush", bus.flush_o, 1);
    chk("jalr_taken_cnt", bus.taken_cnt_o, 1);
    wait_idle("jalr_idle_timeout");

    // funct3=010: illegal pulse, no redirect, still counted.
    drive(1, T_BR, 3'd2, 32'h100, 32'h20, 32'd1, 32'd1);
    tick();
    drive(0, T_ALU, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("ill_pulse", bus.illegal_o, 1);
    chk("ill_rv", bus.redirect_valid_o, 0);
    chk("ill_branch_cnt", bus.branch_cnt_o, 3);
    tick();
    chk("ill_pulse_end", bus.illegal_o, 0);

    // Reset in the middle of a flush.
    drive(1, T_JAL, 3'd0, 32'h100, 32'h8, 32'd0, 32'd0);
    tick();
    drive(0, T_ALU, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    chk("midflush_flush", bus.flush_o, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midflush_flush_clr", bus.flush_o, 0);
    chk("midflush_stall_clr", bus.stall_o, 0);
    chk("midflush_rv_clr", bus.redirect_valid_o, 0);
    chk("midflush_pc_clr", bus.redirect_pc_o, 0);
    chk("midflush_bc_clr", bus.branch_cnt_o, 0);
    chk("midflush_tc_clr", bus.taken_cnt_o, 0);

    // Counter saturation: 17 taken JALs into a 4-bit counter.
    for (int i = 0; i < 17; i++) begin
      drive(1, T_JAL, 3'd0, 32'h1000, 32'h10, 32'd0, 32'd0);
      tick();
      drive(0, T_ALU, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
      wait_idle("sat_idle_timeout");
    end
    chk("sat_taken_cnt", bus.taken_cnt_o, 4'hF);
    chk("sat_branch_cnt", bus.branch_cnt_o, 4'hF);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      int          sel;
      logic [6:0]  op;
      logic [31:0] r1, r2;
      sel = $urandom_range(0, 9);
      op  = (sel < 5) ? T_BR : (sel < 7) ? T_JAL : (sel < 9) ? T_JALR : T_ALU;
      r1  = $urandom();
      r2  = ($urandom_range(0, 3) == 0) ? r1 : $urandom();
      drive($urandom_range(0, 9) < 7, op, 3'($urandom_range(0, 7)),
            $urandom() & 32'hFFFF_FFFC, $urandom(), r1, r2);
      bus.redirect_ready_i = $urandom_range(0, 1);
      reset = ($urandom_range(0, 99) < 2);
      tick();
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
